// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among NUM_REQ producers,
// granting each owner up to MAX_BURST back-to-back writes and stalling all grants while the fifo is full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          r_state, w_state_n;
  logic [IW-1:0]   r_ptr, w_ptr_n, r_owner, w_owner_n, w_start, w_win, w_gidx;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            w_found, w_cont, w_go;
  // modulo-NUM_REQ reduction of a sum of two indices, valid for non-power-of-two NUM_REQ
  function automatic logic [IW-1:0] wrap(input logic [IW:0] s);
    return (s >= (IW+1)'(NUM_REQ)) ? IW'(s - (IW+1)'(NUM_REQ)) : IW'(s);
  endfunction
  always_comb begin
    w_cont  = (r_state == HOLD) && req[r_owner] && (r_cnt < CW'(MAX_BURST));
    w_start = (r_state == HOLD) ? wrap({1'b0, r_owner} + (IW+1)'(1)) : r_ptr;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap({1'b0, w_start} + (IW+1)'(k))]) begin
        w_found = 1'b1;
        w_win   = wrap({1'b0, w_start} + (IW+1)'(k));
      end
    end
    w_go        = reset && !fifo_full && (w_cont || w_found);
    w_gidx      = w_cont ? r_owner : w_win;
    gnt         = w_go ? (NUM_REQ'(1) << w_gidx) : '0;
    fifo_wr     = w_go;
    fifo_w_data = w_go ? req_data[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    gnt_id      = !reset ? '0 : (w_go ? w_gidx : r_owner);
  end
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_owner_n = r_owner;
    w_cnt_n   = r_cnt;
    if (w_go && w_cont) begin
      w_cnt_n = r_cnt + CW'(1);
    end else if (w_go) begin
      w_owner_n = w_win;
      w_cnt_n   = CW'(1);
      w_state_n = (MAX_BURST > 1) ? HOLD : IDLE;
      w_ptr_n   = (MAX_BURST > 1) ? r_ptr : wrap({1'b0, w_win} + (IW+1)'(1));
    end else if (!fifo_full && r_state == HOLD) begin
      w_state_n = IDLE;
      w_ptr_n   = w_start;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_owner <= w_owner_n;
      r_cnt   <= w_cnt_n;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo write port (wr, w_data, full) between NUM_REQ producers. Each granted requester may hold the port for up to MAX_BURST consecutive writes. Grants are suppressed while the fifo is full, so no write is ever lost or duplicated. The block sits directly in front of the fifo; the fifo read side is untouched.

Parameters:
DATA_WIDTH, 8, width of each requester word and of fifo_w_data
NUM_REQ, 4, number of requesters (2..16)
MAX_BURST, 2, maximum consecutive grants to one owner before forced rotation (1..15)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req  input  NUM_REQ  per-requester write request; req_data must be valid while req is high
req_data  input  NUM_REQ*DATA_WIDTH  flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot accept; gnt[i]=1 means req_data[i] is written at this rising edge
fifo_full  input  1  full flag from the fifo
fifo_wr  output  1  fifo write strobe, equal to |gnt
fifo_w_data  output  DATA_WIDTH  data of the granted requester; 0 when there is no grant
gnt_id  output  $clog2(NUM_REQ)  index of the current or last owner

Behaviour:
- State: FSM {IDLE, HOLD}, rotating pointer ptr, owner register, burst counter cnt.
- Reset (async, reset=0): state=IDLE, ptr=0, owner=0, cnt=0. gnt, fifo_wr, fifo_w_data and gnt_id are forced to 0 combinationally while reset=0.
- gnt, fifo_wr and fifo_w_data are combinational from the current state, req and fifo_full. There is zero-cycle latency from req to gnt.
- Arbitration (used in IDLE and on release from HOLD): the winner is the first i with req[i]=1, searching ptr, ptr+1, ... and wrapping modulo NUM_REQ.
- IDLE: if any req and !fifo_full, grant the winner. At the edge, set owner=winner and cnt=1, then go to HOLD if MAX_BURST>1; otherwise set ptr=winner+1 and stay in IDLE.
- HOLD, continue case: req[owner]=1 and cnt<MAX_BURST and !fifo_full. Grant owner and increment cnt.
- HOLD, release case: req[owner]=0 or cnt==MAX_BURST. In the same cycle, arbitrate with the search starting at owner+1 (wrapping), so there is no bubble cycle. The old owner wins only if no other req is set.
  - A winner with !fifo_full becomes the new owner with cnt=1.
  - With no req, go to IDLE and set ptr=owner+1.
- fifo_full=1: gnt=0 and fifo_wr=0. State, owner, cnt and ptr all hold. A full-stall cycle does not consume burst count.
- Requesters hold req and req_data stable until gnt. A req may drop without a grant; nothing is written for it.
- Each gnt accepts exactly one word. A requester with more data keeps req high.
- gnt is always one-hot or zero. fifo_w_data is 0 when there is no grant.
- Pointer and owner arithmetic wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

Test Plan:
1. Single requester. Release reset with req=0 for 2 cycles, so gnt=0 and fifo_wr=0. Then req[0]=1 with data 0x05 held for 3 cycles. Expect gnt[0] on 3 consecutive cycles with no bubble; the third grant starts a new burst with cnt=1. fifo_w_data=0x05 on each grant.
2. All four requesters. Set req=4'b1111 continuously with data 0x10/0x20/0x30/0x40. Expect gnt_id sequence 0,0,1,1,2,2,3,3,0. fifo_wr=1 every cycle.
3. Full stall mid-burst. Requester 1 is granted once, then fifo_full=1 for 3 cycles. Expect gnt=0 and fifo_wr=0 for those 3 cycles. After full drops, requester 1 gets exactly one more grant (cnt reaches 2), then rotation moves to requester 2.
4. Early release. req=4'b1010 and owner 1 drops req after 1 write. Expect the next cycle to grant requester 3 with no idle cycle.
5. Reset mid-burst. Assert reset=0 asynchronously between edges while gnt[2]=1. Expect gnt, fifo_wr and fifo_w_data to drop to 0 immediately. After release with req=4'b1111, the first grant is requester 0.
6. Integration with an 8-deep, 8-bit fifo.
   - Requesters 0 and 2 each present 5 words (0x01–0x05 and 0x21–0x25).
   - Expect exactly 8 words accepted, in order 01,02,21,22,03,04,23,24, after which full blocks all grants.
   - Draining 2 words lets the remaining words in.
   - Read-out order matches gnt order and no word is duplicated.
